ysyx_25040101_lsu: RTL and testbench
====================================

YSYX_25040101_LSU -- requirements
Module: ysyx_25040101_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of the byte address.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid_i, input, 1 bit: an access request from the execute stage is present.
REQ-005 SHALL have port req_ready_o, output, 1 bit: the LSU can accept a request.
REQ-006 SHALL have port req_wen_i, input, 1 bit: 1 means store, 0 means load.
REQ-007 SHALL have port req_addr_i, input, ADDR_W bits: the byte address.
REQ-008 SHALL have port req_wdata_i, input, 32 bits: store data, taken from rs2.
REQ-009 SHALL have port req_funct3_i, input, 3 bits: the RV32I width and sign encoding.
REQ-010 SHALL have port req_rd_addr_i, input, 5 bits: the load destination register.
REQ-011 SHALL have ports mem_req_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, ADDR_W, word-aligned), mem_wdata_o (output, 32) and mem_wstrb_o (output, 4).
REQ-012 SHALL have ports mem_gnt_i (input, 1), mem_rvalid_i (input, 1), mem_rdata_i (input, 32) and mem_err_i (input, 1).
REQ-013 SHALL have ports rd_wen_o (output, 1), rd_addr_o (output, 5) and rd_data_o (output, 32), which feed the register file write port.
REQ-014 SHALL have ports done_o, misalign_o and err_o, each an output of 1 bit and each a single-cycle completion flag.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT and RESP; every output except req_ready_o SHALL be driven from a register.
REQ-016 In IDLE, req_ready_o SHALL be 1; the FSM SHALL accept a request when req_valid_i and req_ready_o are both 1, latching all req_* inputs; in every other state req_ready_o SHALL be 0.
REQ-017 On accept, the FSM SHALL go from IDLE to RESP with misalign_o pending when the address is misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0; no memory access SHALL occur.
REQ-018 On accept, the FSM SHALL go from IDLE to RESP with err_o pending when funct3 is unsupported: loads 011, 110, 111; stores any value above 010; no memory access SHALL occur.
REQ-019 Otherwise the FSM SHALL go from IDLE to REQ.
REQ-020 In REQ, mem_req_o SHALL be held at 1 with stable address, data and strobe until mem_gnt_i=1, then the FSM SHALL move to WAIT.
REQ-021 mem_rvalid_i SHALL be ignored in REQ.
REQ-022 In WAIT, the FSM SHALL stay until mem_rvalid_i=1, capture mem_rdata_i and mem_err_i, then move to RESP.
REQ-023 RESP SHALL last exactly one cycle: done_o=1 and at most one of misalign_o and err_o set; the FSM SHALL then return to IDLE.
REQ-024 In RESP, rd_wen_o SHALL be 1 only for a load with no misalign, no error and rd_addr!=0; rd_addr_o and rd_data_o SHALL be valid whenever rd_wen_o=1.
REQ-025 Minimum latency SHALL be 3 cycles from accept to done_o, with gnt and rvalid each arriving in the first cycle they are eligible.
REQ-026 mem_addr_o SHALL equal {addr[ADDR_W-1:2], 2'b00}.
REQ-027 For SB, mem_wdata_o SHALL be the byte replicated into all 4 lanes and mem_wstrb_o SHALL be 1<<addr[1:0].
REQ-028 For SH, mem_wdata_o SHALL be the halfword replicated into both halves and mem_wstrb_o SHALL be 0011 when addr[1]=0, 1100 when addr[1]=1.
REQ-029 For SW, mem_wstrb_o SHALL be 1111.
REQ-030 For loads, mem_wstrb_o SHALL be 0000.
REQ-031 Load data SHALL take the lane selected by addr[1:0]: LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word unchanged.

Reset
REQ-032 While rst=0, the FSM SHALL be in IDLE and every registered output SHALL be 0, effective immediately and without waiting for a clock edge.
REQ-033 A reset in REQ or WAIT SHALL abort the access with no done_o; mem_req_o SHALL drop asynchronously; a late mem_rvalid_i SHALL be ignored.

Structure
REQ-034 Package ysyx_25040101_pkg SHALL hold the funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state enum.
REQ-035 Combinational lane logic (store replicate and strobe, load extract and extend) SHALL reside in sub-module ysyx_25040101_lsu_align.

Verification
REQ-036 The bench SHALL cover: LB at addr 0x8000_0003 with mem_rdata_i=0x80FF_0011 and immediate gnt/rvalid -> rd_data_o=0xFFFF_FF80, rd_wen_o=1, done_o 3 cycles after accept.
REQ-037 The bench SHALL cover: SH at addr 0x8000_0002 with wdata 0x1234_ABCD -> mem_wdata_o=0xABCD_ABCD, mem_wstrb_o=1100, mem_we_o=1; in RESP rd_wen_o=0.
REQ-038 The bench SHALL cover: LW at addr 0x8000_0001 -> misalign_o=1 and done_o in the cycle after accept, no mem_req_o, rd_wen_o=0.
REQ-039 The bench SHALL cover: LHU with gnt delayed 4 cycles and rvalid delayed 2 cycles, rdata 0xBEEF_0000 at addr 0x...2 -> mem_req_o stable 5 cycles, rd_data_o=0x0000_BEEF, req_ready_o=0 throughout.
REQ-040 The bench SHALL cover: LW to rd=0, and separately rvalid with mem_err_i=1 -> err_o=1 in the error case and rd_wen_o=0 in both cases.
REQ-041 The bench SHALL cover: rst low in WAIT -> mem_req_o and done_o 0 immediately, req_ready_o=1 after release, a stray rvalid produces no write.

Source files
------------

// File: rtl/ysyx_25040101_pkg.sv
// Shared encodings and helpers for the load/store unit.
package ysyx_25040101_pkg;

  // RV32I funct3 encodings for loads and stores.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  // True when funct3 names a real load/store width.
  function automatic logic f3_supported(input logic wen, input logic [2:0] f3);
    logic ok;
    if (wen) begin
      ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
    end else begin
      ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    end
    return ok;
  endfunction

  // Width is carried in funct3[1:0]; byte accesses can never be misaligned.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_25040101_lsu_align.sv
// Byte-lane steering: store replicate/strobe generation and load extract/extend.
module ysyx_25040101_lsu_align
  import ysyx_25040101_pkg::*;
(
  input  logic        st_we_i,
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_strb_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the operand into every lane it may land in, strobe the real one.
  always_comb begin
    st_data_o = '0;
    st_strb_o = '0;
    if (st_we_i) begin
      case (st_funct3_i)
        SB: begin
          st_data_o = {4{st_wdata_i[7:0]}};
          st_strb_o = 4'b0001 << st_off_i;
        end
        SH: begin
          st_data_o = {2{st_wdata_i[15:0]}};
          st_strb_o = st_off_i[1] ? 4'b1100 : 4'b0011;
        end
        SW: begin
          st_data_o = st_wdata_i;
          st_strb_o = 4'b1111;
        end
        default: ;
      endcase
    end
  end

  // Load side: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    ld_byte = ld_rdata_i[7:0];
    case (ld_off_i)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_funct3_i)
      LB:      ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_data_o = {{16{ld_half[15]}}, ld_half};
      LBU:     ld_data_o = {24'h0, ld_byte};
      LHU:     ld_data_o = {16'h0, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/ysyx_25040101_lsu.sv
// Load/store unit: one outstanding access, registered memory and writeback outputs.
module ysyx_25040101_lsu
  import ysyx_25040101_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wen_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [4:0]        req_rd_addr_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_err_i,
  output logic              rd_wen_o,
  output logic [4:0]        rd_addr_o,
  output logic [31:0]       rd_data_o,
  output logic              done_o,
  output logic              misalign_o,
  output logic              err_o
);

  state_e state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              rd_wen_q, rd_wen_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;
  logic              err_q, err_d;

  // Latched request attributes needed after the accept cycle.
  logic              wen_q, wen_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;

  logic [31:0]       st_data;
  logic [3:0]        st_strb;
  logic [31:0]       ld_data;

  assign req_ready_o = (state_q == StIdle);

  ysyx_25040101_lsu_align u_align (
    .st_we_i     (req_wen_i),
    .st_funct3_i (req_funct3_i),
    .st_off_i    (req_addr_i[1:0]),
    .st_wdata_i  (req_wdata_i),
    .st_data_o   (st_data),
    .st_strb_o   (st_strb),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (mem_rdata_i),
    .ld_data_o   (ld_data)
  );

  // Next-state and registered-output logic; completion flags default low so RESP is one cycle.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    wen_d       = wen_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_wen_d    = 1'b0;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          wen_d     = req_wen_i;
          f3_d      = req_funct3_i;
          off_d     = req_addr_i[1:0];
          rd_addr_d = req_rd_addr_i;
          if (!f3_supported(req_wen_i, req_funct3_i)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StResp;
          end else if (f3_misaligned(req_funct3_i, req_addr_i[1:0])) begin
            misalign_d = 1'b1;
            done_d     = 1'b1;
            state_d    = StResp;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_wen_i;
            mem_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
            mem_wdata_d = st_data;
            mem_wstrb_d = st_strb;
            state_d     = StReq;
          end
        end
      end
      StReq: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (mem_rvalid_i) begin
          rd_data_d = ld_data;
          err_d     = mem_err_i;
          done_d    = 1'b1;
          rd_wen_d  = !wen_q && !mem_err_i && (rd_addr_q != 5'd0);
          state_d   = StResp;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rd_wen_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      err_q       <= 1'b0;
      wen_q       <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rd_wen_q    <= rd_wen_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      err_q       <= err_d;
      wen_q       <= wen_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign rd_wen_o    = rd_wen_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign done_o      = done_q;
  assign misalign_o  = misalign_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ysyx_25040101_lsu.sv
// Directed and randomized bench for the LSU against a byte-level reference model.
module tb_ysyx_25040101_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_wen_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [2:0]  req_funct3_i = '0;
  logic [4:0]  req_rd_addr_i = '0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic        rd_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        done_o;
  logic        misalign_o;
  logic        err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_25040101_lsu #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_wen_i     (req_wen_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_funct3_i  (req_funct3_i),
    .req_rd_addr_i (req_rd_addr_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_wstrb_o   (mem_wstrb_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_err_i     (mem_err_i),
    .rd_wen_o      (rd_wen_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_o     (rd_data_o),
    .done_o        (done_o),
    .misalign_o    (misalign_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: one complete transaction, expectations derived from access size and byte offset.
  task automatic run_txn(input string tag, input logic wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [31:0] rdata, input logic merr,
                         input int g, input int r);
    bit          sup;
    bit          mis;
    int          size;
    logic [31:0] e_wd;
    logic [3:0]  e_st;
    logic [31:0] sh;
    logic [31:0] mask;
    logic [31:0] e_ld;
    logic        e_wen;

    sup  = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    mis  = sup && ((addr & 32'(size - 1)) != 0);

    if (size == 1)      e_wd = {4{wdata[7:0]}};
    else if (size == 2) e_wd = {2{wdata[15:0]}};
    else                e_wd = wdata;
    e_st = wen ? 4'(((1 << size) - 1) << addr[1:0]) : 4'b0000;

    sh   = rdata >> (8 * addr[1:0]);
    mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    e_ld = sh & mask;
    if (!f3[2] && size < 4 && e_ld[8 * size - 1]) e_ld = e_ld | ~mask;
    e_wen = !wen && !merr && (rd != 5'd0);

    req_valid_i   = 1'b1;
    req_wen_i     = wen;
    req_funct3_i  = f3;
    req_addr_i    = addr;
    req_wdata_i   = wdata;
    req_rd_addr_i = rd;
    chk({tag, ".ready_idle"}, 32'(req_ready_o), 32'd1);
    tick;
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;

    if (!sup || mis) begin
      chk({tag, ".done_early"}, 32'(done_o), 32'd1);
      chk({tag, ".misalign"}, 32'(misalign_o), 32'(mis));
      chk({tag, ".err"}, 32'(err_o), 32'(!sup));
      chk({tag, ".no_memreq"}, 32'(mem_req_o), 32'd0);
      chk({tag, ".rd_wen"}, 32'(rd_wen_o), 32'd0);
    end else begin
      for (int k = 0; k <= g; k++) begin
        chk({tag, ".req_hold"}, 32'(mem_req_o), 32'd1);
        chk({tag, ".addr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
        chk({tag, ".we"}, 32'(mem_we_o), 32'(wen));
        chk({tag, ".wstrb"}, 32'(mem_wstrb_o), 32'(e_st));
        if (wen) chk({tag, ".wdata"}, mem_wdata_o, e_wd);
        chk({tag, ".ready_busy"}, 32'(req_ready_o), 32'd0);
        chk({tag, ".done_busy"}, 32'(done_o), 32'd0);
        mem_gnt_i    = (k == g);
        mem_rvalid_i = (k < g) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata_i  = $urandom;
        mem_err_i    = 1'($urandom_range(0, 1));
        tick;
      end
      mem_gnt_i = 1'b0;
      for (int k = 0; k <= r; k++) begin
        chk({tag, ".req_drop"}, 32'(mem_req_o), 32'd0);
        chk({tag, ".ready_wait"}, 32'(req_ready_o), 32'd0);
        chk({tag, ".done_wait"}, 32'(done_o), 32'd0);
        mem_rvalid_i = (k == r);
        mem_rdata_i  = (k == r) ? rdata : $urandom;
        mem_err_i    = (k == r) ? merr : 1'b0;
        tick;
      end
      mem_rvalid_i = 1'b0;
      mem_err_i    = 1'b0;
      chk({tag, ".done"}, 32'(done_o), 32'd1);
      chk({tag, ".err_resp"}, 32'(err_o), 32'(merr));
      chk({tag, ".mis_resp"}, 32'(misalign_o), 32'd0);
      chk({tag, ".rd_wen"}, 32'(rd_wen_o), 32'(e_wen));
      if (e_wen) begin
        chk({tag, ".rd_addr"}, 32'(rd_addr_o), 32'(rd));
        chk({tag, ".rd_data"}, rd_data_o, e_ld);
      end
    end
    tick;
    chk({tag, ".done_clr"}, 32'(done_o), 32'd0);
    chk({tag, ".flags_clr"}, 32'({misalign_o, err_o, rd_wen_o}), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    // Reset with clocks both absent and running.
    #1 rst = 1'b0;
    #2;
    chk("rst.outs", 32'({mem_req_o, mem_we_o, rd_wen_o, done_o, misalign_o, err_o}), 32'd0);
    chk("rst.vec", mem_addr_o | mem_wdata_o | rd_data_o | 32'(mem_wstrb_o) | 32'(rd_addr_o),
        32'd0);
    chk("rst.ready", 32'(req_ready_o), 32'd1);
    tick;
    tick;
    chk("rst.hold", 32'({mem_req_o, done_o, rd_wen_o}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick;

    run_txn("lb_neg", 1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd7, 32'h80FF_0011, 1'b0, 0, 0);
    run_txn("sh_hi", 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 5'd9, 32'h0, 1'b0, 0, 0);
    run_txn("lw_mis", 1'b0, 3'b010, 32'h8000_0001, 32'h0, 5'd3, 32'h0, 1'b0, 0, 0);
    run_txn("lhu_slow", 1'b0, 3'b101, 32'h8000_0102, 32'h0, 5'd4, 32'hBEEF_0000, 1'b0, 4, 2);
    run_txn("lw_x0", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd0, 32'hCAFE_F00D, 1'b0, 0, 1);
    run_txn("lw_err", 1'b0, 3'b010, 32'h8000_0014, 32'h0, 5'd5, 32'h1111_2222, 1'b1, 1, 0);
    run_txn("ld_bad", 1'b0, 3'b110, 32'h8000_0000, 32'h0, 5'd5, 32'h0, 1'b0, 0, 0);
    run_txn("st_bad", 1'b1, 3'b100, 32'h8000_0000, 32'h55, 5'd5, 32'h0, 1'b0, 0, 0);
    run_txn("sb_b1", 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 5'd1, 32'h0, 1'b0, 2, 0);
    run_txn("sw", 1'b1, 3'b010, 32'h8000_0020, 32'hDEAD_BEEF, 5'd1, 32'h0, 1'b0, 0, 3);

    // Reset while the request is being held: mem_req_o must fall without a clock edge.
    req_valid_i = 1'b1; req_wen_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h8000_0040; req_rd_addr_i = 5'd6;
    tick;
    req_valid_i = 1'b0;
    chk("rstreq.pre", 32'(mem_req_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstreq.memreq", 32'(mem_req_o), 32'd0);
    chk("rstreq.ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    tick;

    // Reset while waiting for data; the late response must be dropped.
    req_valid_i = 1'b1;
    tick;
    req_valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rstwait.memreq", 32'(mem_req_o), 32'd0);
    chk("rstwait.done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    chk("rstwait.ready", 32'(req_ready_o), 32'd1);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h7777_7777;
    tick;
    mem_rvalid_i = 1'b0;
    chk("rstwait.stray_wen", 32'(rd_wen_o), 32'd0);
    chk("rstwait.stray_done", 32'(done_o), 32'd0);
    tick;
    chk("rstwait.stray_wen2", 32'(rd_wen_o), 32'd0);
    chk("rstwait.ready2", 32'(req_ready_o), 32'd1);

    for (int i = 0; i < 80; i++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      run_txn("rand", 1'($urandom_range(0, 1)), f3, addr, $urandom, 5'($urandom_range(0, 31)),
              $urandom, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
